// File: rtl/alu_share_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU controller.
// The slave modport is the controller; the master modport is its environment.
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req0_op;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             resp0_valid;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp_result;
  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, alu_result,
    output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
           resp0_valid, resp1_valid, resp_result, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, alu_result,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
           resp0_valid, resp1_valid, resp_result, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between two
// requesters; multiply (code 3) holds the ALU inputs for MUL_CYCLES cycles.
module alu_share_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input logic        clk,
  input logic        reset,
  alu_share_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD  = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             ready0;
  logic             ready1;
  logic             handshake;
  logic             capture;
  logic             load_cnt;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       ctrl_q;
  logic [WIDTH-1:0] result_q;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    handshake = 1'b0;
    capture   = 1'b0;
    load_cnt  = 1'b0;
    case (state)
      IDLE: begin
        ready0    = bus.req0_valid && !grant;
        ready1    = bus.req1_valid && grant;
        handshake = ready0 || ready1;
        if (handshake) state_nxt = EXEC;
      end
      EXEC: begin
        if (ctrl_q == 3'd3 && MUL_MULTI) begin
          load_cnt  = 1'b1;
          state_nxt = MUL;
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      MUL: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operands stay frozen from the handshake until the next one, so the ALU
  // output is stable for however long the multiply is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      ctrl_q     <= 3'd0;
      result_q   <= '0;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      if (handshake) begin
        alu_a_q    <= grant ? bus.req1_a  : bus.req0_a;
        alu_b_q    <= grant ? bus.req1_b  : bus.req0_b;
        ctrl_q     <= grant ? bus.req1_op : bus.req0_op;
        owner      <= grant;
        last_grant <= grant;
      end
      if (load_cnt) begin
        cnt <= MUL_LOAD;
      end else if (state == MUL && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) result_q <= bus.alu_result;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.resp_result = result_q;
  assign bus.resp0_valid = (state == RESP) && !owner;
  assign bus.resp1_valid = (state == RESP) && owner;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus a random
// phase compared against a transaction-level model of grant order and latency.
module tb_alu_share_ctrl;

  localparam int WIDTH = 32;
  localparam int MULC  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_share_if #(.WIDTH(WIDTH)) bus ();
  alu_share_if #(.WIDTH(WIDTH)) bus1 ();

  alu_share_ctrl #(.WIDTH(WIDTH), .MUL_CYCLES(MULC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  alu_share_ctrl #(.WIDTH(WIDTH), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a * b;
      3'd4:    return a & ~b;
      3'd5:    return a | ~b;
      3'd6:    return a - b;
      default: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
    endcase
  endfunction

  // The external combinational ALU for each instance.
  always_comb bus.alu_result  = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  always_comb bus1.alu_result = alu_ref(bus1.alu_ctrl, bus1.alu_a, bus1.alu_b);

  task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int n, input logic v, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [2:0] op);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state
  logic             rv [2];
  logic [WIDTH-1:0] ra [2];
  logic [WIDTH-1:0] rb [2];
  logic [2:0]       rop [2];
  bit               hs_prev [2];
  int               hs_cyc, resp_cyc, free_cyc, exp_owner, w, lat;
  logic [WIDTH-1:0] exp_res;
  logic             mlast, e0, e1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    apply_stimulus(0, 1'b0, '0, '0, 3'd0);
    apply_stimulus(1, 1'b0, '0, '0, 3'd0);
    bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_op = 3'd0;
    bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_op = 3'd0;
    #1 reset = 1'b1;
    #1;
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_resp0", bus.resp0_valid, 1'b0);
    check_bit("rst_resp1", bus.resp1_valid, 1'b0);
    check_output("rst_result", bus.resp_result, '0);
    check_output("rst_alu_a", bus.alu_a, '0);
    check_output("rst_alu_b", bus.alu_b, '0);
    check_output("rst_alu_ctrl", WIDTH'(bus.alu_ctrl), '0);
    check_bit("rst_ready0_idle", bus.req0_ready, 1'b0);
    apply_stimulus(0, 1'b1, 9, 4, 3'd6);
    apply_stimulus(1, 1'b1, 3, 8, 3'd7);
    #1;
    check_bit("rst_tie_ready0", bus.req0_ready, 1'b1);
    check_bit("rst_tie_ready1", bus.req1_ready, 1'b0);
    apply_stimulus(0, 1'b0, 9, 4, 3'd6);
    apply_stimulus(1, 1'b0, 3, 8, 3'd7);
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();

    // Tie and round-robin: handshakes every third cycle, alternating owner.
    apply_stimulus(0, 1'b1, 9, 4, 3'd6);
    apply_stimulus(1, 1'b1, 3, 8, 3'd7);
    #1;
    for (int k = 0; k < 4; k++) begin
      check_bit("rr_ready0", bus.req0_ready, (k % 2) == 0);
      check_bit("rr_ready1", bus.req1_ready, (k % 2) == 1);
      next_cycle();
      if (k == 3) begin
        apply_stimulus(0, 1'b0, 9, 4, 3'd6);
        apply_stimulus(1, 1'b0, 3, 8, 3'd7);
      end
      #1;
      check_bit("rr_busy", bus.busy, 1'b1);
      check_bit("rr_exec_ready", bus.req0_ready | bus.req1_ready, 1'b0);
      next_cycle(); #1;
      check_bit("rr_resp0", bus.resp0_valid, (k % 2) == 0);
      check_bit("rr_resp1", bus.resp1_valid, (k % 2) == 1);
      check_output("rr_result", bus.resp_result, ((k % 2) == 0) ? 32'd5 : 32'd1);
      next_cycle(); #1;
    end
    check_bit("rr_end_busy", bus.busy, 1'b0);

    // Single ADD from requester 0.
    apply_stimulus(0, 1'b1, 5, 7, 3'd2);
    #1;
    check_bit("add_ready0", bus.req0_ready, 1'b1);
    next_cycle();
    apply_stimulus(0, 1'b0, 5, 7, 3'd2);
    #1;
    check_output("add_ctrl", WIDTH'(bus.alu_ctrl), 32'd2);
    check_bit("add_busy_t1", bus.busy, 1'b1);
    check_bit("add_resp1_t1", bus.resp1_valid, 1'b0);
    next_cycle(); #1;
    check_bit("add_resp0", bus.resp0_valid, 1'b1);
    check_output("add_result", bus.resp_result, 32'd12);
    check_bit("add_busy_t2", bus.busy, 1'b1);
    check_bit("add_resp1_t2", bus.resp1_valid, 1'b0);
    next_cycle(); #1;
    check_bit("add_busy_t3", bus.busy, 1'b0);
    check_bit("add_resp0_t3", bus.resp0_valid, 1'b0);

    // Multiply held for MULC cycles; operands on the request bus are scrambled.
    apply_stimulus(1, 1'b1, 32'h10000, 32'h10003, 3'd3);
    #1;
    check_bit("mul_ready1", bus.req1_ready, 1'b1);
    next_cycle();
    apply_stimulus(1, 1'b0, 32'hdeadbeef, 32'h1234, 3'd5);
    #1;
    for (int c = 1; c <= MULC; c++) begin
      check_output("mul_alu_a", bus.alu_a, 32'h10000);
      check_output("mul_alu_b", bus.alu_b, 32'h10003);
      check_output("mul_ctrl", WIDTH'(bus.alu_ctrl), 32'd3);
      check_bit("mul_no_resp", bus.resp1_valid, 1'b0);
      check_bit("mul_busy", bus.busy, 1'b1);
      next_cycle(); #1;
    end
    check_bit("mul_resp1", bus.resp1_valid, 1'b1);
    check_bit("mul_resp0", bus.resp0_valid, 1'b0);
    check_output("mul_result", bus.resp_result, 32'h00030000);
    next_cycle(); #1;
    check_bit("mul_resp1_once", bus.resp1_valid, 1'b0);
    check_bit("mul_idle", bus.busy, 1'b0);

    // Reset in the middle of a multiply.
    apply_stimulus(0, 1'b1, 3, 5, 3'd3);
    #1;
    check_bit("mrst_ready0", bus.req0_ready, 1'b1);
    next_cycle();
    apply_stimulus(0, 1'b0, 3, 5, 3'd3);
    next_cycle();
    reset = 1'b1;
    #1;
    check_bit("mrst_busy", bus.busy, 1'b0);
    check_output("mrst_result", bus.resp_result, '0);
    check_bit("mrst_resp0", bus.resp0_valid, 1'b0);
    check_output("mrst_alu_a", bus.alu_a, '0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle(); #1;
      check_bit("mrst_no_resp0", bus.resp0_valid, 1'b0);
      check_bit("mrst_no_busy", bus.busy, 1'b0);
    end
    apply_stimulus(0, 1'b1, 1, 1, 3'd2);
    apply_stimulus(1, 1'b1, 2, 2, 3'd2);
    #1;
    check_bit("mrst_tie_ready0", bus.req0_ready, 1'b1);
    check_bit("mrst_tie_ready1", bus.req1_ready, 1'b0);
    next_cycle();
    apply_stimulus(0, 1'b0, 1, 1, 3'd2);
    apply_stimulus(1, 1'b0, 2, 2, 3'd2);
    next_cycle(); #1;
    check_bit("mrst_tie_resp0", bus.resp0_valid, 1'b1);
    check_output("mrst_tie_result", bus.resp_result, 32'd2);
    next_cycle();

    // Requester 0 shows valid only while the block is executing for requester 1.
    apply_stimulus(1, 1'b1, 20, 6, 3'd6);
    #1;
    check_bit("wd_ready1", bus.req1_ready, 1'b1);
    next_cycle();
    apply_stimulus(1, 1'b0, 20, 6, 3'd6);
    apply_stimulus(0, 1'b1, 7, 7, 3'd2);
    #1;
    check_bit("wd_ready0_exec", bus.req0_ready, 1'b0);
    next_cycle();
    apply_stimulus(0, 1'b0, 7, 7, 3'd2);
    #1;
    check_bit("wd_resp1", bus.resp1_valid, 1'b1);
    check_output("wd_result", bus.resp_result, 32'd14);
    check_bit("wd_resp0", bus.resp0_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      next_cycle(); #1;
      check_bit("wd_no_busy", bus.busy, 1'b0);
      check_bit("wd_no_resp0", bus.resp0_valid, 1'b0);
    end

    // Single-cycle multiply build behaves like any other op.
    bus1.req0_valid = 1'b1; bus1.req0_a = 6; bus1.req0_b = 7; bus1.req0_op = 3'd3;
    #1;
    check_bit("m1_ready0", bus1.req0_ready, 1'b1);
    next_cycle();
    bus1.req0_valid = 1'b0;
    #1;
    check_bit("m1_busy", bus1.busy, 1'b1);
    check_bit("m1_no_resp_t1", bus1.resp0_valid, 1'b0);
    next_cycle(); #1;
    check_bit("m1_resp0", bus1.resp0_valid, 1'b1);
    check_output("m1_result", bus1.resp_result, 32'd42);
    next_cycle(); #1;
    check_bit("m1_idle", bus1.busy, 1'b0);

    // Random traffic against a transaction-level model.
    reset = 1'b1;
    #1 reset = 1'b0;
    apply_stimulus(0, 1'b0, '0, '0, 3'd0);
    apply_stimulus(1, 1'b0, '0, '0, 3'd0);
    next_cycle();
    hs_cyc = -100; resp_cyc = -100; free_cyc = 0; exp_owner = 0; exp_res = '0;
    mlast = 1'b1;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0; ra[n] = '0; rb[n] = '0; rop[n] = 3'd0; hs_prev[n] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (hs_prev[n]) rv[n] = 1'b0;
        hs_prev[n] = 1'b0;
        if (!rv[n]) begin
          if ($urandom_range(1, 0) == 1) begin
            rv[n]  = 1'b1;
            ra[n]  = $urandom;
            rb[n]  = ($urandom_range(1, 0) == 1) ? WIDTH'($urandom_range(15, 0)) : $urandom;
            rop[n] = ($urandom_range(3, 0) == 0) ? 3'd3 : 3'($urandom_range(7, 0));
          end
        end else if ($urandom_range(9, 0) == 0) begin
          rv[n] = 1'b0;
        end
        apply_stimulus(n, rv[n], ra[n], rb[n], rop[n]);
      end
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (cyc >= free_cyc) begin
        if (rv[0] && rv[1]) begin
          if (mlast) e0 = 1'b1; else e1 = 1'b1;
        end else if (rv[0]) e0 = 1'b1;
        else if (rv[1]) e1 = 1'b1;
      end
      check_bit("rnd_ready0", bus.req0_ready, e0);
      check_bit("rnd_ready1", bus.req1_ready, e1);
      check_bit("rnd_resp0", bus.resp0_valid, cyc == resp_cyc && exp_owner == 0);
      check_bit("rnd_resp1", bus.resp1_valid, cyc == resp_cyc && exp_owner == 1);
      check_bit("rnd_busy", bus.busy, cyc > hs_cyc && cyc < free_cyc);
      if (cyc == resp_cyc) check_output("rnd_result", bus.resp_result, exp_res);
      if (e0 || e1) begin
        w         = e1 ? 1 : 0;
        lat       = (rop[w] == 3'd3) ? MULC + 1 : 2;
        hs_cyc    = cyc;
        resp_cyc  = cyc + lat;
        free_cyc  = resp_cyc + 1;
        exp_owner = w;
        exp_res   = alu_ref(rop[w], ra[w], rb[w]);
        mlast     = e1;
        hs_prev[w] = 1'b1;
      end
      next_cycle();
    end
    apply_stimulus(0, 1'b0, '0, '0, 3'd0);
    apply_stimulus(1, 1'b0, '0, '0, 3'd0);
    repeat (10) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbiter and sequencer that shares the single combinational ALU between two requesters, such as the execute stage and a multi-cycle helper unit. It performs round-robin grant and a valid/ready accept handshake, drives registered operands and the 3-bit control code into the external ALU, and captures the result. Multiply (code 3) is held for a programmable number of cycles. The block sits beside the ALU in the execute stage and returns a one-cycle response pulse to the granted requester.

## Interface
- WIDTH, 32, operand/result width
- MUL_CYCLES, 4, cycles the ALU inputs are held for control code 3; legal range 1..15
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; all state returns to reset values immediately
- req0_valid, req1_valid  input  1  requester has an operation pending
- req0_ready, req1_ready  output  1  operation accepted this cycle when ready && valid
- req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands
- req0_op, req1_op  input  3  ALU control code (0 AND, 1 OR, 2 ADD, 3 MUL low word, 4 AND-NOT, 5 OR-NOT, 6 SUB, 7 SLT)
- alu_a, alu_b  output  WIDTH  registered operands to the ALU
- alu_ctrl  output  3  registered control code to the ALU
- alu_result  input  WIDTH  combinational ALU result
- resp0_valid, resp1_valid  output  1  one-cycle pulse: resp_result belongs to that requester
- resp_result  output  WIDTH  captured result; holds until the next capture
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, EXEC, MUL, RESP. Reset state is IDLE.
- IDLE:
  - Grant: if only one requester is valid, it wins. If both are valid, the requester not named by last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - reqN_ready = (state==IDLE) && grant==N. It is combinational and may depend on the valid inputs.
  - On handshake: latch a, b and op into alu_a, alu_b and alu_ctrl; record owner; set last_grant = owner; go to EXEC.
- EXEC:
  - op != 3: capture alu_result into resp_result at the end of the cycle; go to RESP.
  - op == 3 and MUL_CYCLES == 1: same as op != 3.
  - op == 3 and MUL_CYCLES > 1: load the counter with MUL_CYCLES-2; go to MUL.
- MUL: decrement the counter each cycle. When the counter is 0, capture alu_result and go to RESP.
- RESP: assert resp_valid for the owner only; go to IDLE.
- ready is low in EXEC, MUL and RESP. Requesters hold valid and operands stable until the handshake. Dropping valid before the handshake is legal and causes no acceptance.
- alu_a, alu_b and alu_ctrl change only on a handshake. They hold their values through IDLE.
- Width: the block does no arithmetic on operands and passes the result through unmodified. Only the low WIDTH bits of the multiply are returned, because the ALU truncates.
- Reset mid-operation: the operation is abandoned and no response pulse is issued. On reset:
  - state = IDLE
  - counter = 0
  - last_grant = 1

## Timing
- Reset values:
  - req*_ready: combinational; 1 for the tie-winner if valid, else 0
  - resp0_valid, resp1_valid: 0
  - resp_result: 0
  - alu_a, alu_b: 0
  - alu_ctrl: 0
  - busy: 0
- Non-multiply op, handshake at cycle T:
  - EXEC at T+1, result captured at the end of T+1
  - resp_valid and resp_result valid during T+2
  - next possible handshake at T+3
- Multiply op, handshake at T:
  - capture at the end of cycle T+MUL_CYCLES
  - resp_valid during T+MUL_CYCLES+1
- Peak throughput: one operation per 3 cycles.
- Only one of resp0_valid and resp1_valid is high in any cycle. Neither is high in two consecutive cycles.

## Test plan
- Single ADD: req0 a=5, b=7, op=2 at T.
  - Required: req0_ready=1 at T, alu_ctrl=2 at T+1, resp0_valid=1 with resp_result=12 at T+2, resp1_valid=0 throughout, busy high during T+1..T+2.
- Tie and round-robin: both requesters continuously valid, req0 op=6 (9-4), req1 op=7 (3<8).
  - Required: first grant to req0, resp0 result 5; second grant to req1, resp1 result 1; grants then alternate.
  - Required: handshakes at T, T+3, T+6.
- Multiply, MUL_CYCLES=4: req1 a=0x10000, b=0x10003, op=3 at T.
  - Required: alu inputs stable T+1..T+4, resp1_valid at T+5, resp_result=0x00030000.
- Multiply with MUL_CYCLES=1 (second build): response at T+2, identical to ADD timing.
- Reset during MUL: assert reset at T+2 of a multiply.
  - Required: immediately IDLE, busy=0, resp_result=0, no resp pulse.
  - Required: the next tie after release goes to req0.
- Valid withdrawal: req0_valid high for one cycle while the block is in EXEC, then dropped.
  - Required: no handshake and no response for req0; req1's in-flight result is unaffected.
